// File: rtl/elink_tx_arbiter_pkg.sv
// Shared definitions for the elink transmit arbiter: packet width, source codes,
// emesh packet field offsets and the counter helper used by the starvation logic.
// Pure declarations, no state and no timing of its own.
package elink_tx_arbiter_pkg;

  // Default emesh packet width in bits.
  localparam int PW = 104;

  // Width of the per-channel starvation counters; covers thresholds up to 255.
  localparam int CNT_W = 8;

  // Source code reported alongside each merged packet.
  typedef enum logic [1:0] {
    SRC_WR = 2'd0,
    SRC_RD = 2'd1,
    SRC_RR = 2'd2
  } src_e;

  // emesh packet field offsets (lsb / msb). The arbiter never looks inside a
  // packet; these are here so neighbouring blocks agree on the layout.
  localparam int F_WRITE_LSB    = 0;
  localparam int F_WRITE_MSB    = 0;
  localparam int F_DATAMODE_LSB = 1;
  localparam int F_DATAMODE_MSB = 2;
  localparam int F_CTRLMODE_LSB = 3;
  localparam int F_CTRLMODE_MSB = 6;
  localparam int F_DSTADDR_LSB  = 8;
  localparam int F_DSTADDR_MSB  = 39;
  localparam int F_DATA_LSB     = 40;
  localparam int F_DATA_MSB     = 71;
  localparam int F_SRCADDR_LSB  = 72;
  localparam int F_SRCADDR_MSB  = 103;

  // Increment that sticks once the limit is reached.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                               input logic [CNT_W-1:0] limit);
    if (value >= limit) begin
      return limit;
    end
    return value + CNT_W'(1);
  endfunction

endpackage

// File: rtl/elink_tx_arbiter_starve_cnt.sv
// Saturating wait counter for one request channel; raises starved at STARVE.
// Latency: count and starved are registered, reflecting the previous cycle.
// Backpressure: passive observer of the channel's access and wait signals.
module elink_starve_cnt
  import elink_tx_arbiter_pkg::*;
#(
  parameter int STARVE = 15
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic access,
  input  logic blocked,
  output logic starved
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Count only cycles spent waiting; a transfer or a dropped request restarts from zero.
  always_comb begin
    count_d = '0;
    if (access && blocked) begin
      count_d = sat_inc(count_q, LIMIT);
    end
  end

  // Counter register, cleared by the asynchronous reset.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign starved = (count_q == LIMIT);

endmodule

// File: rtl/elink_tx_arbiter.sv
// Merges wr / rd / rr emesh request streams into one registered transmit stream.
// Latency: exactly one cycle from an accepted input to etx_access/etx_packet.
// Backpressure: etx_wait stalls the output register; all inputs wait while it is stalled.
module elink_tx_arbiter #(
  parameter int PW     = 104,
  parameter int STARVE = 15
) (
  input  logic          sys_clk,
  input  logic          reset,
  input  logic          txwr_access,
  input  logic [PW-1:0] txwr_packet,
  output logic          txwr_wait,
  input  logic          txrd_access,
  input  logic [PW-1:0] txrd_packet,
  output logic          txrd_wait,
  input  logic          txrr_access,
  input  logic [PW-1:0] txrr_packet,
  output logic          txrr_wait,
  output logic          etx_access,
  output logic [PW-1:0] etx_packet,
  output logic [1:0]    etx_src,
  input  logic          etx_wait
);

  import elink_tx_arbiter_pkg::*;

  logic          ready;
  logic          wr_starved;
  logic          rd_starved;
  logic          above_wr;
  logic          above_rd;
  logic          above_rr;
  logic          grant_vld;
  src_e          grant_src;
  logic [PW-1:0] grant_packet;

  // The output register can take a new packet unless it holds one the
  // transmitter is refusing. Reset is folded in so every wait reads 1 while
  // reset is high and nothing can be accepted in that cycle.
  assign ready = !reset && !(etx_access && etx_wait);

  // Which higher-ranked channels are requesting this cycle, per channel.
  // Ranking: starved rd, starved wr, rr, rd, wr.
  always_comb begin
    above_rr = (rd_starved && txrd_access) || (wr_starved && txwr_access);
    above_rd = 1'b0;
    if (!rd_starved) begin
      above_rd = (wr_starved && txwr_access) || txrr_access;
    end
    above_wr = rd_starved && txrd_access;
    if (!wr_starved) begin
      above_wr = txrr_access || txrd_access;
    end
  end

  assign txwr_wait = !ready || above_wr;
  assign txrd_wait = !ready || above_rd;
  assign txrr_wait = !ready || above_rr;

  // Pick the highest-ranked requesting channel; consistent with the waits above,
  // so the winner is always the one channel whose wait is low when ready.
  always_comb begin
    grant_vld    = 1'b0;
    grant_src    = SRC_WR;
    grant_packet = txwr_packet;
    if (rd_starved && txrd_access) begin
      grant_vld    = 1'b1;
      grant_src    = SRC_RD;
      grant_packet = txrd_packet;
    end else if (wr_starved && txwr_access) begin
      grant_vld    = 1'b1;
      grant_src    = SRC_WR;
      grant_packet = txwr_packet;
    end else if (txrr_access) begin
      grant_vld    = 1'b1;
      grant_src    = SRC_RR;
      grant_packet = txrr_packet;
    end else if (txrd_access) begin
      grant_vld    = 1'b1;
      grant_src    = SRC_RD;
      grant_packet = txrd_packet;
    end else if (txwr_access) begin
      grant_vld    = 1'b1;
      grant_src    = SRC_WR;
      grant_packet = txwr_packet;
    end
  end

  // Output register: load the winner when ready, clear valid on an idle ready
  // cycle (payload and source are left as they were), freeze while stalled.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      etx_access <= 1'b0;
      etx_packet <= '0;
      etx_src    <= SRC_WR;
    end else if (ready) begin
      etx_access <= grant_vld;
      if (grant_vld) begin
        etx_packet <= grant_packet;
        etx_src    <= grant_src;
      end
    end
  end

  elink_starve_cnt #(
    .STARVE (STARVE)
  ) u_wr_starve (
    .sys_clk (sys_clk),
    .reset   (reset),
    .access  (txwr_access),
    .blocked (txwr_wait),
    .starved (wr_starved)
  );

  elink_starve_cnt #(
    .STARVE (STARVE)
  ) u_rd_starve (
    .sys_clk (sys_clk),
    .reset   (reset),
    .access  (txrd_access),
    .blocked (txrd_wait),
    .starved (rd_starved)
  );

endmodule

// File: tb/tb_elink_tx_arbiter.sv
// Directed bench for elink_tx_arbiter with STARVE=3.
// Inputs change 1ns after the rising edge; outputs are sampled at #1 or on the falling edge.
// Each scenario task compares against hand-derived expectations.
module tb_elink_tx_arbiter;

  localparam int PW = 104;

  localparam logic [PW-1:0] P_WR  = 104'h57_0000_1111_2222_3333_4444_5555;
  localparam logic [PW-1:0] P_RD  = 104'h52_0000_AAAA_BBBB_CCCC_DDDD_EEEE;
  localparam logic [PW-1:0] P_RR  = 104'h5A_0000_0123_4567_89AB_CDEF_0011;
  localparam logic [PW-1:0] P_H   = 104'h48_0000_DEAD_BEEF_CAFE_F00D_1234;
  localparam logic [PW-1:0] P_X   = 104'h58_0000_0BAD_0BAD_0BAD_0BAD_0BAD;
  localparam logic [PW-1:0] P_W2  = 104'h77_0000_0000_0000_0000_0000_0077;
  localparam logic [PW-1:0] P_R2  = 104'h88_0000_0000_0000_0000_0000_0088;
  localparam logic [PW-1:0] RB    = 104'h99_0000_0000_0000_0000_0000_0000;
  localparam logic [PW-1:0] BB    = 104'h66_0000_0000_0000_0000_0000_0000;

  logic          sys_clk;
  logic          reset;
  logic          txwr_access;
  logic [PW-1:0] txwr_packet;
  logic          txwr_wait;
  logic          txrd_access;
  logic [PW-1:0] txrd_packet;
  logic          txrd_wait;
  logic          txrr_access;
  logic [PW-1:0] txrr_packet;
  logic          txrr_wait;
  logic          etx_access;
  logic [PW-1:0] etx_packet;
  logic [1:0]    etx_src;
  logic          etx_wait;

  int checks = 0;
  int errors = 0;

  elink_tx_arbiter #(
    .PW     (PW),
    .STARVE (3)
  ) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .txwr_access (txwr_access),
    .txwr_packet (txwr_packet),
    .txwr_wait   (txwr_wait),
    .txrd_access (txrd_access),
    .txrd_packet (txrd_packet),
    .txrd_wait   (txrd_wait),
    .txrr_access (txrr_access),
    .txrr_packet (txrr_packet),
    .txrr_wait   (txrr_wait),
    .etx_access  (etx_access),
    .etx_packet  (etx_packet),
    .etx_src     (etx_src),
    .etx_wait    (etx_wait)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic sync();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    txwr_access = 1'b1;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (etx_access !== 1'b0) begin
      errors++; $display("FAIL reset_access: got %b want 0", etx_access);
    end
    checks++;
    if (etx_packet !== '0) begin
      errors++; $display("FAIL reset_packet: got %h want 0", etx_packet);
    end
    checks++;
    if (etx_src !== 2'd0) begin
      errors++; $display("FAIL reset_src: got %0d want 0", etx_src);
    end
    checks++;
    if ({txwr_wait, txrd_wait, txrr_wait} !== 3'b111) begin
      errors++; $display("FAIL reset_waits: got %b want 111", {txwr_wait, txrd_wait, txrr_wait});
    end
    txwr_access = 1'b0;
    reset       = 1'b0;
    #1;
    checks++;
    if ({txwr_wait, txrd_wait, txrr_wait} !== 3'b000) begin
      errors++; $display("FAIL release_waits: got %b want 000", {txwr_wait, txrd_wait, txrr_wait});
    end
    sync();
    checks++;
    if (etx_access !== 1'b0 || {txwr_wait, txrd_wait, txrr_wait} !== 3'b000) begin
      errors++; $display("FAIL release_idle: access %b waits %b want 0 000",
                         etx_access, {txwr_wait, txrd_wait, txrr_wait});
    end
  endtask

  task automatic test_priority();
    sync();
    txwr_access = 1'b1; txwr_packet = P_WR;
    txrd_access = 1'b1; txrd_packet = P_RD;
    txrr_access = 1'b1; txrr_packet = P_RR;
    @(negedge sys_clk);
    checks++;
    if ({txwr_wait, txrd_wait, txrr_wait} !== 3'b110) begin
      errors++; $display("FAIL prio_waits0: got %b want 110", {txwr_wait, txrd_wait, txrr_wait});
    end
    sync();
    checks++;
    if (etx_access !== 1'b1 || etx_src !== 2'd2 || etx_packet !== P_RR) begin
      errors++; $display("FAIL prio_rr: access %b src %0d pkt %h want 1 2 %h",
                         etx_access, etx_src, etx_packet, P_RR);
    end
    txrr_access = 1'b0;
    @(negedge sys_clk);
    checks++;
    if ({txwr_wait, txrd_wait, txrr_wait} !== 3'b100) begin
      errors++; $display("FAIL prio_waits1: got %b want 100", {txwr_wait, txrd_wait, txrr_wait});
    end
    sync();
    checks++;
    if (etx_access !== 1'b1 || etx_src !== 2'd1 || etx_packet !== P_RD) begin
      errors++; $display("FAIL prio_rd: access %b src %0d pkt %h want 1 1 %h",
                         etx_access, etx_src, etx_packet, P_RD);
    end
    txrd_access = 1'b0;
    sync();
    checks++;
    if (etx_access !== 1'b1 || etx_src !== 2'd0 || etx_packet !== P_WR) begin
      errors++; $display("FAIL prio_wr: access %b src %0d pkt %h want 1 0 %h",
                         etx_access, etx_src, etx_packet, P_WR);
    end
    txwr_access = 1'b0;
    sync();
    checks++;
    if (etx_access !== 1'b0 || etx_src !== 2'd0 || etx_packet !== P_WR) begin
      errors++; $display("FAIL idle_hold: access %b src %0d pkt %h want 0 0 %h",
                         etx_access, etx_src, etx_packet, P_WR);
    end
  endtask

  task automatic test_back_to_back();
    sync();
    txwr_access = 1'b1;
    txwr_packet = BB;
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      checks++;
      if (txwr_wait !== 1'b0) begin
        errors++; $display("FAIL b2b_wait%0d: got %b want 0", i, txwr_wait);
      end
      sync();
      checks++;
      if (etx_access !== 1'b1 || etx_src !== 2'd0 || etx_packet !== BB + PW'(i)) begin
        errors++; $display("FAIL b2b_out%0d: access %b src %0d pkt %h want 1 0 %h",
                           i, etx_access, etx_src, etx_packet, BB + PW'(i));
      end
      txwr_packet = BB + PW'(i + 1);
    end
    txwr_access = 1'b0;
    sync();
    checks++;
    if (etx_access !== 1'b0) begin
      errors++; $display("FAIL b2b_end: got %b want 0", etx_access);
    end
  endtask

  task automatic test_hold();
    sync();
    txrd_access = 1'b1; txrd_packet = P_H;
    sync();
    checks++;
    if (etx_access !== 1'b1 || etx_src !== 2'd1 || etx_packet !== P_H) begin
      errors++; $display("FAIL hold_load: access %b src %0d pkt %h want 1 1 %h",
                         etx_access, etx_src, etx_packet, P_H);
    end
    txrd_access = 1'b0;
    etx_wait    = 1'b1;
    txwr_access = 1'b1; txwr_packet = P_WR;
    txrr_access = 1'b1; txrr_packet = P_RR;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      checks++;
      if ({txwr_wait, txrd_wait, txrr_wait} !== 3'b111) begin
        errors++; $display("FAIL hold_waits%0d: got %b want 111", i, {txwr_wait, txrd_wait, txrr_wait});
      end
      checks++;
      if (etx_access !== 1'b1 || etx_src !== 2'd1 || etx_packet !== P_H) begin
        errors++; $display("FAIL hold_out%0d: access %b src %0d pkt %h want 1 1 %h",
                           i, etx_access, etx_src, etx_packet, P_H);
      end
      sync();
    end
    txwr_access = 1'b0;
    txrr_access = 1'b0;
    etx_wait    = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (etx_access !== 1'b1 || etx_packet !== P_H || {txwr_wait, txrd_wait, txrr_wait} !== 3'b000) begin
      errors++; $display("FAIL hold_release: access %b pkt %h waits %b want 1 %h 000",
                         etx_access, etx_packet, {txwr_wait, txrd_wait, txrr_wait}, P_H);
    end
    for (int i = 0; i < 2; i++) begin
      sync();
      checks++;
      if (etx_access !== 1'b0) begin
        errors++; $display("FAIL hold_once%0d: access %b want 0", i, etx_access);
      end
    end
  endtask

  task automatic test_starve_wr();
    int            rr_sent;
    logic [1:0]    exp_src;
    logic [PW-1:0] exp_pkt;
    rr_sent = 0;
    sync();
    txrr_access = 1'b1; txrr_packet = RB;
    txwr_access = 1'b1; txwr_packet = P_W2;
    for (int k = 0; k < 6; k++) begin
      @(negedge sys_clk);
      if (k <= 3) begin
        checks++;
        if (txwr_wait !== (k < 3) || txrr_wait !== (k == 3)) begin
          errors++; $display("FAIL starve_wr_waits%0d: wr %b rr %b want %b %b",
                             k, txwr_wait, txrr_wait, (k < 3), (k == 3));
        end
      end
      sync();
      exp_src = (k == 3) ? 2'd0 : 2'd2;
      exp_pkt = (k == 3) ? P_W2 : RB + PW'(rr_sent);
      checks++;
      if (etx_access !== 1'b1 || etx_src !== exp_src || etx_packet !== exp_pkt) begin
        errors++; $display("FAIL starve_wr_out%0d: access %b src %0d pkt %h want 1 %0d %h",
                           k, etx_access, etx_src, etx_packet, exp_src, exp_pkt);
      end
      if (k == 3) begin
        txwr_access = 1'b0;
      end else begin
        rr_sent++;
        txrr_packet = RB + PW'(rr_sent);
      end
    end
    txrr_access = 1'b0;
    sync();
    checks++;
    if (etx_access !== 1'b0) begin
      errors++; $display("FAIL starve_wr_end: got %b want 0", etx_access);
    end
  endtask

  task automatic test_both_starved();
    int            rr_sent;
    logic [2:0]    exp_w   [6];
    logic [1:0]    exp_s   [6];
    logic [PW-1:0] exp_pkt;
    exp_w   = '{3'b110, 3'b110, 3'b110, 3'b101, 3'b011, 3'b110};
    exp_s   = '{2'd2, 2'd2, 2'd2, 2'd1, 2'd0, 2'd2};
    rr_sent = 0;
    sync();
    txrr_access = 1'b1; txrr_packet = RB;
    txrd_access = 1'b1; txrd_packet = P_R2;
    txwr_access = 1'b1; txwr_packet = P_W2;
    for (int k = 0; k < 6; k++) begin
      @(negedge sys_clk);
      checks++;
      if ({txwr_wait, txrd_wait, txrr_wait} !== exp_w[k]) begin
        errors++; $display("FAIL both_waits%0d: got %b want %b", k, {txwr_wait, txrd_wait, txrr_wait}, exp_w[k]);
      end
      sync();
      if (k == 3) exp_pkt = P_R2;
      else if (k == 4) exp_pkt = P_W2;
      else exp_pkt = RB + PW'(rr_sent);
      checks++;
      if (etx_access !== 1'b1 || etx_src !== exp_s[k] || etx_packet !== exp_pkt) begin
        errors++; $display("FAIL both_out%0d: access %b src %0d pkt %h want 1 %0d %h",
                           k, etx_access, etx_src, etx_packet, exp_s[k], exp_pkt);
      end
      if (k == 3) begin
        txrd_access = 1'b0;
      end else if (k == 4) begin
        txwr_access = 1'b0;
      end else begin
        rr_sent++;
        txrr_packet = RB + PW'(rr_sent);
      end
    end
    txrr_access = 1'b0;
    sync();
  endtask

  task automatic test_reset_mid_hold();
    sync();
    etx_wait    = 1'b0;
    txrd_access = 1'b1; txrd_packet = P_X;
    sync();
    txrd_access = 1'b0;
    etx_wait    = 1'b1;
    checks++;
    if (etx_access !== 1'b1 || etx_packet !== P_X) begin
      errors++; $display("FAIL midrst_load: access %b pkt %h want 1 %h", etx_access, etx_packet, P_X);
    end
    @(negedge sys_clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (etx_access !== 1'b0 || etx_packet !== '0 || etx_src !== 2'd0) begin
      errors++; $display("FAIL midrst_async: access %b pkt %h src %0d want 0 0 0",
                         etx_access, etx_packet, etx_src);
    end
    checks++;
    if ({txwr_wait, txrd_wait, txrr_wait} !== 3'b111) begin
      errors++; $display("FAIL midrst_waits: got %b want 111", {txwr_wait, txrd_wait, txrr_wait});
    end
    @(posedge sys_clk);
    @(negedge sys_clk);
    reset    = 1'b0;
    etx_wait = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sync();
      checks++;
      if (etx_access !== 1'b0 || etx_packet !== '0) begin
        errors++; $display("FAIL midrst_gone%0d: access %b pkt %h want 0 0", i, etx_access, etx_packet);
      end
    end
  endtask

  initial begin
    sys_clk     = 1'b0;
    reset       = 1'b1;
    txwr_access = 1'b0; txwr_packet = '0;
    txrd_access = 1'b0; txrd_packet = '0;
    txrr_access = 1'b0; txrr_packet = '0;
    etx_wait    = 1'b0;
    test_reset();
    test_priority();
    test_back_to_back();
    test_hold();
    test_starve_wr();
    test_both_starved();
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
